// File: rtl/boot_loader.sv
// boot_loader: receives a framed byte stream (SYNC, LEN, data, CSUM), writes the image into
// the core's memory and holds the core in reset until the image checks out.
// Optional build macro: BOOT_LOADER_ZERO_FILL_EN zero-fills words L..MEM_DEPTH-1 after a good image.
module boot_loader #(
    parameter int                 ADDR_W    = 5,
    parameter int                 DATA_W    = 8,
    parameter int                 MEM_DEPTH = 32,
    parameter logic [DATA_W-1:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error
);

    // One extra bit so the pointer/count can hold MEM_DEPTH itself.
    localparam int PTR_W = ADDR_W + 1;

`ifdef BOOT_LOADER_ZERO_FILL_EN
    typedef enum logic [2:0] {
        WAIT_SYNC, LEN, DATA, CSUM, FILL, DONE, ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        WAIT_SYNC, LEN, DATA, CSUM, DONE, ERROR
    } state_t;
`endif

    state_t            state, nxt_state;
    logic [PTR_W-1:0]  count, nxt_count;
    logic [PTR_W-1:0]  wr_ptr, nxt_ptr;
    logic [DATA_W-1:0] sum, nxt_sum;
    logic              nxt_wr;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_data;
    logic              nxt_ready;
    logic              accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_SYNC;
            count     <= '0;
            wr_ptr    <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= nxt_state;
            count     <= nxt_count;
            wr_ptr    <= nxt_ptr;
            sum       <= nxt_sum;
            in_ready  <= nxt_ready;
            mem_wr    <= nxt_wr;
            mem_addr  <= nxt_addr;
            mem_data  <= nxt_data;
            cpu_rst_n <= (nxt_state == DONE);
            done      <= (nxt_state == DONE);
            error     <= (nxt_state == ERROR);
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_count = count;
        nxt_ptr   = wr_ptr;
        nxt_sum   = sum;
        nxt_wr    = 1'b0;
        nxt_addr  = mem_addr;
        nxt_data  = mem_data;

        case (state)
            WAIT_SYNC, ERROR: begin
                if (accept && in_data == SYNC_BYTE) begin
                    nxt_state = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if (in_data == '0 || in_data > DATA_W'(MEM_DEPTH)) begin
                        nxt_state = ERROR;
                    end else begin
                        nxt_count = in_data[PTR_W-1:0];
                        nxt_ptr   = '0;
                        nxt_sum   = '0;
                        nxt_state = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    nxt_wr   = 1'b1;
                    nxt_addr = wr_ptr[ADDR_W-1:0];
                    nxt_data = in_data;
                    nxt_sum  = sum + in_data;
                    nxt_ptr  = wr_ptr + PTR_W'(1);
                    if (wr_ptr + PTR_W'(1) == count) begin
                        nxt_state = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (in_data != sum) begin
                        nxt_state = ERROR;
`ifdef BOOT_LOADER_ZERO_FILL_EN
                    // First fill word is issued on the checksum edge so the release
                    // delay is exactly MEM_DEPTH-L cycles.
                    end else if (count != PTR_W'(MEM_DEPTH)) begin
                        nxt_state = FILL;
                        nxt_wr    = 1'b1;
                        nxt_addr  = count[ADDR_W-1:0];
                        nxt_data  = '0;
                        nxt_ptr   = count + PTR_W'(1);
`endif
                    end else begin
                        nxt_state = DONE;
                    end
                end
            end
`ifdef BOOT_LOADER_ZERO_FILL_EN
            FILL: begin
                if (wr_ptr == PTR_W'(MEM_DEPTH)) begin
                    nxt_state = DONE;
                end else begin
                    nxt_wr   = 1'b1;
                    nxt_addr = wr_ptr[ADDR_W-1:0];
                    nxt_data = '0;
                    nxt_ptr  = wr_ptr + PTR_W'(1);
                end
            end
`endif
            DONE: begin
                nxt_state = DONE;
            end
            default: begin
                nxt_state = WAIT_SYNC;
            end
        endcase

`ifdef BOOT_LOADER_ZERO_FILL_EN
        nxt_ready = (nxt_state != DONE) && (nxt_state != FILL);
`else
        nxt_ready = (nxt_state != DONE);
`endif
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table vectors, directed timing sequences and random framed streams,
// all checked against a frame-level reference parser.
module tb_boot_loader;

    localparam int DEPTH = 32;
`ifdef BOOT_LOADER_ZERO_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_rst_n;
    logic       done;
    logic       error;

    always #5 clk = ~clk;

    boot_loader #(
        .ADDR_W(5), .DATA_W(8), .MEM_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
    );

    int total = 0;
    int bad   = 0;
    int max_gap = 0;
    logic [7:0]  stim[$];
    logic [12:0] dut_wr[$];
    logic [12:0] exp_wr[$];

    typedef struct packed {
        logic [8*40-1:0] seq;
        int unsigned     n;
        int unsigned     nwr;
        int unsigned     fill_n;
        logic            ok;
        logic            err;
        logic [12:0]     last_wr;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Write monitor; a write while the core is released would corrupt a running program.
    always @(negedge clk) begin
        if (mem_wr) begin
            dut_wr.push_back({mem_addr, mem_data});
            chk("wr_while_released", {31'd0, cpu_rst_n}, 32'd0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: parse the whole byte list by the frame rules; returns 0 pending, 1 done, 2 error.
    function automatic int model();
        int i = 0;
        int st = 0;
        int L, k;
        logic [7:0] s;
        exp_wr.delete();
        while (i < stim.size()) begin
            if (stim[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            st = 0;
            if (i >= stim.size()) break;
            L = int'(stim[i]);
            i++;
            if (L == 0 || L > DEPTH) begin
                st = 2;
                continue;
            end
            s = 8'h00;
            k = 0;
            while (k < L && i < stim.size()) begin
                exp_wr.push_back({5'(k), stim[i]});
                s = s + stim[i];
                i++;
                k++;
            end
            if (k < L || i >= stim.size()) break;
            if (stim[i] == s) begin
`ifdef BOOT_LOADER_ZERO_FILL_EN
                for (int a = L; a < DEPTH; a++) exp_wr.push_back({5'(a), 8'h00});
`endif
                st = 1;
                break;
            end
            st = 2;
            i++;
        end
        return st;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        if (max_gap > 0) begin
            int g = $urandom_range(max_gap, 0);
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("handshake_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dut_wr.delete();
    endtask

    task automatic settle();
        int w = 0;
        while (!(done || error) && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("settle", {31'd0, done | error}, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_stream();
        do_reset();
        foreach (stim[k]) send_byte(stim[k]);
        settle();
    endtask

    task automatic check_run(input string tag);
        int st = model();
        chk({tag, "_nwr"}, dut_wr.size(), exp_wr.size());
        for (int k = 0; k < exp_wr.size() && k < dut_wr.size(); k++)
            chk({tag, "_wr"}, {19'd0, dut_wr[k]}, {19'd0, exp_wr[k]});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, st == 1});
        chk({tag, "_err"}, {31'd0, error}, {31'd0, st == 2});
        chk({tag, "_cpurst"}, {31'd0, cpu_rst_n}, {31'd0, st == 1});
    endtask

    task automatic add_vec(input int unsigned nwr, input int unsigned fill_n, input logic ok,
                           input logic err, input logic [12:0] last_wr);
        vec_t v;
        v = '0;
        v.n = stim.size();
        foreach (stim[k]) v.seq[8*k +: 8] = stim[k];
        v.nwr = nwr;
        v.fill_n = fill_n;
        v.ok = ok;
        v.err = err;
        v.last_wr = last_wr;
        vt.push_back(v);
    endtask

    function automatic logic [7:0] junk();
        logic [7:0] b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    task automatic push_frame(input int kind);
        int L;
        logic [7:0] s = 8'h00;
        logic [7:0] b;
        stim.push_back(8'hA5);
        if (kind == 2) begin
            L = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, 33);
            stim.push_back(8'(L));
            return;
        end
        L = $urandom_range(DEPTH, 1);
        stim.push_back(8'(L));
        for (int k = 0; k < L; k++) begin
            b = 8'($urandom);
            stim.push_back(b);
            s = s + b;
        end
        stim.push_back(kind == 1 ? s + 8'($urandom_range(255, 1)) : s);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;

        // Reset values and first-cycle in_ready.
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("rst_mem_data", {24'd0, mem_data}, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rdy_before_clk", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rdy_after_clk", {31'd0, in_ready}, 32'd1);

        // Directed latency sequence: A5,03,11,22,33,66 back to back.
        dut_wr.delete();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        chk("t1_wr0", {19'd0, mem_wr, mem_addr, mem_data}, {19'd0, 1'b1, 5'd0, 8'h11});
        send_byte(8'h22);
        chk("t1_wr1", {19'd0, mem_wr, mem_addr, mem_data}, {19'd0, 1'b1, 5'd1, 8'h22});
        send_byte(8'h33);
        chk("t1_wr2", {19'd0, mem_wr, mem_addr, mem_data}, {19'd0, 1'b1, 5'd2, 8'h33});
        chk("t1_done_early", {31'd0, done | cpu_rst_n}, 32'd0);
        send_byte(8'h66);
`ifdef BOOT_LOADER_ZERO_FILL_EN
        chk("t1_fill_first", {19'd0, mem_wr, mem_addr, mem_data}, {19'd0, 1'b1, 5'd3, 8'h00});
        chk("t1_done_held", {31'd0, done}, 32'd0);
`else
        chk("t1_done", {30'd0, done, cpu_rst_n}, 32'd3);
        chk("t1_err", {31'd0, error}, 32'd0);
        chk("t1_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("t1_no_dup", {31'd0, mem_wr}, 32'd0);
`endif
        stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        settle();
        check_run("t1");

        // Asynchronous reset in the middle of DATA, then a clean reload.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        chk("ar_pre_wr", {31'd0, mem_wr}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("ar_addr_data", {19'd0, mem_addr, mem_data}, 32'd0);
        chk("ar_flags", {29'd0, in_ready, cpu_rst_n, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        stim = '{8'hA5, 8'h01, 8'h5A, 8'h5A};
        run_stream();
        check_run("ar_reload");

`ifdef BOOT_LOADER_ZERO_FILL_EN
        // Zero fill: 30 back-to-back zero writes to 2..31, then done.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'h65);
        for (int k = 0; k < 30; k++) begin
            chk("fill_wr", {19'd0, mem_wr, mem_addr, mem_data}, {19'd0, 1'b1, 5'(k + 2), 8'h00});
            chk("fill_done_low", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        chk("fill_end", {29'd0, mem_wr, done, cpu_rst_n}, 32'd3);
`endif

        // Table vectors: stream, data writes, zero-fill count, outcome, last data write.
        stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        add_vec(3, 29, 1'b1, 1'b0, {5'd2, 8'h33});
        stim = '{8'h00, 8'h7F, 8'hA5, 8'h01, 8'hC3, 8'hC3};
        add_vec(1, 31, 1'b1, 1'b0, {5'd0, 8'hC3});
        stim = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04};
        add_vec(2, 0, 1'b0, 1'b1, {5'd1, 8'h02});
        stim = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04, 8'hA5, 8'h01, 8'h05, 8'h05};
        add_vec(3, 31, 1'b1, 1'b0, {5'd0, 8'h05});
        stim = '{8'hA5, 8'h00};
        add_vec(0, 0, 1'b0, 1'b1, 13'd0);
        stim = '{8'hA5, 8'h21};
        add_vec(0, 0, 1'b0, 1'b1, 13'd0);
        stim = '{8'hA5, 8'h20};
        for (int k = 0; k < 32; k++) stim.push_back(8'h01);
        stim.push_back(8'h20);
        add_vec(32, 0, 1'b1, 1'b0, {5'd31, 8'h01});

        max_gap = 0;
        foreach (vt[i]) begin
            stim.delete();
            for (int k = 0; k < vt[i].n; k++) stim.push_back(vt[i].seq[8*k +: 8]);
            run_stream();
            chk("vec_done", {31'd0, done}, {31'd0, vt[i].ok});
            chk("vec_err", {31'd0, error}, {31'd0, vt[i].err});
            chk("vec_nwr", dut_wr.size(), vt[i].nwr + ((FILL_ON && vt[i].ok) ? vt[i].fill_n : 0));
            if (vt[i].nwr > 0 && dut_wr.size() >= vt[i].nwr)
                chk("vec_last_wr", {19'd0, dut_wr[vt[i].nwr - 1]}, {19'd0, vt[i].last_wr});
            check_run("vec");
        end

        // The 0x03 frame with in_valid dropping randomly between bytes.
        max_gap = 3;
        for (int r = 0; r < 3; r++) begin
            stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
            run_stream();
            check_run("stall");
        end

        // Random streams: junk, failed attempts, then a final frame of random kind.
        for (int it = 0; it < 25; it++) begin
            stim.delete();
            repeat ($urandom_range(3, 0)) stim.push_back(junk());
            repeat ($urandom_range(2, 0)) push_frame($urandom_range(2, 1));
            push_frame($urandom_range(2, 0));
            max_gap = $urandom_range(3, 0);
            run_stream();
            check_run("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
